// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator control unit.
// Optional JN support is enabled by defining ACC_CTRL_JN_EN.
package acc_ctrl_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JN  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OPERAND,
        ST_EXEC,
        ST_STORE,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_ALWAYS,
        BR_ZERO,
        BR_NEG
    } br_cond_e;

    typedef struct packed {
        logic     mem_op;
        logic     store;
        logic     branch;
        br_cond_e br_cond;
        logic     halt;
        logic     illegal;
    } op_class_t;

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode classifier and ALU function select.
// Opcode 8 (JN) decodes as a branch only when ACC_CTRL_JN_EN is defined.
module acc_ctrl_decode
    import acc_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output op_class_t  cls_o,
    output alu_op_e    alu_op_o
);

    // Classify opcode; anything unrecognised is illegal and runs as a NOP
    always_comb begin
        cls_o    = '0;
        alu_op_o = ALU_PASS_B;
        case (opcode_i)
            OP_NOP: begin
            end
            OP_LDA: cls_o.mem_op = 1'b1;
            OP_ADD: begin
                cls_o.mem_op = 1'b1;
                alu_op_o     = ALU_ADD;
            end
            OP_SUB: begin
                cls_o.mem_op = 1'b1;
                alu_op_o     = ALU_SUB;
            end
            OP_AND: begin
                cls_o.mem_op = 1'b1;
                alu_op_o     = ALU_AND;
            end
            OP_STA: cls_o.store = 1'b1;
            OP_JMP: begin
                cls_o.branch  = 1'b1;
                cls_o.br_cond = BR_ALWAYS;
            end
            OP_JZ: begin
                cls_o.branch  = 1'b1;
                cls_o.br_cond = BR_ZERO;
            end
`ifdef ACC_CTRL_JN_EN
            OP_JN: begin
                cls_o.branch  = 1'b1;
                cls_o.br_cond = BR_NEG;
            end
`endif
            OP_HLT: cls_o.halt = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_control_unit.sv
// Multi-cycle control FSM for a 16-bit accumulator machine.
// Build with ACC_CTRL_JN_EN defined to enable the JN branch.
module acc_control_unit
    import acc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          acc_zero,
    input  logic          acc_neg,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] operand,
    output logic [2:0]    alu_op,
    output logic          load_acc,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          illegal
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] operand_q, operand_d;
    alu_op_e       alu_op_q, alu_op_d;

    op_class_t     cls;
    alu_op_e       dec_alu;
    logic [AW-1:0] ir_addr;
    logic          br_taken;

    assign ir_addr  = ir_q[AW-1:0];
    assign pc       = pc_q;
    assign operand  = operand_q;
    assign alu_op   = alu_op_q;

    acc_ctrl_decode u_decode (
        .opcode_i (ir_q[DW-1:DW-4]),
        .cls_o    (cls),
        .alu_op_o (dec_alu)
    );

    // Resolve branch condition against the accumulator flags
    always_comb begin
        br_taken = 1'b0;
        case (cls.br_cond)
            BR_ALWAYS: br_taken = 1'b1;
            BR_ZERO:   br_taken = acc_zero;
            BR_NEG:    br_taken = acc_neg;
            default:   br_taken = 1'b0;
        endcase
    end

    // Next-state, datapath captures and memory/strobe outputs
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        alu_op_d  = alu_op_q;
        mem_addr  = pc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        load_acc  = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (cls.mem_op) begin
                    alu_op_d = dec_alu;
                    state_d  = ST_OPERAND;
                end else if (cls.store) begin
                    state_d = ST_STORE;
                end else if (cls.branch) begin
                    if (br_taken) pc_d = ir_addr;
                end else if (cls.halt) begin
                    state_d = ST_HALT;
                end else begin
                    illegal = cls.illegal;
                end
            end
            ST_OPERAND: begin
                mem_rd   = 1'b1;
                mem_addr = ir_addr;
                if (mem_ready) begin
                    operand_d = mem_rdata;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load_acc = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_STORE: begin
                mem_wr   = 1'b1;
                mem_addr = ir_addr;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any pending access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            operand_q <= '0;
            alu_op_q  <= ALU_PASS_B;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
            alu_op_q  <= alu_op_d;
        end
    end

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed self-checking bench for acc_control_unit.
// Expectations for opcode 8 follow ACC_CTRL_JN_EN.
module tb_acc_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        acc_zero;
    logic        acc_neg;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] operand;
    logic [2:0]  alu_op;
    logic        load_acc;
    logic [11:0] pc;
    logic        halted;
    logic        illegal;

    acc_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .operand   (operand),
        .alu_op    (alu_op),
        .load_acc  (load_acc),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Behavioural memory with a programmable wait count per access
    logic [15:0] mem [0:4095];
    int          delay;
    int          wcnt;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = (mem_rd || mem_wr) && (wcnt == delay);

    always @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 0;
        else if ((mem_rd || mem_wr) && !mem_ready)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] rd_log[$];
    logic [11:0] wr_log[$];
    logic [2:0]  ld_op[$];
    logic [15:0] ld_val[$];
    int          both_cnt;
    int          ill_cycles;
    int          ill_pulses;
    int          unstable;

    // Observer: samples DUT outputs on the falling edge
    initial begin
        logic        p_req, p_rdy, p_rd, p_wr, p_ill;
        logic [11:0] p_addr;
        p_req = 0; p_rdy = 0; p_rd = 0; p_wr = 0;
        p_ill = 0; p_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 0;
                p_ill = 0;
            end else begin
                if (mem_rd && mem_ready) rd_log.push_back(mem_addr);
                if (mem_wr && mem_ready) wr_log.push_back(mem_addr);
                if (load_acc) begin
                    ld_op.push_back(alu_op);
                    ld_val.push_back(operand);
                end
                if (mem_rd && mem_wr) both_cnt++;
                if (illegal) ill_cycles++;
                if (illegal && !p_ill) ill_pulses++;
                if (p_req && !p_rdy &&
                    (mem_rd !== p_rd || mem_wr !== p_wr ||
                     mem_addr !== p_addr))
                    unstable++;
                p_req  = mem_rd || mem_wr;
                p_rdy  = mem_ready;
                p_rd   = mem_rd;
                p_wr   = mem_wr;
                p_addr = mem_addr;
                p_ill  = illegal;
            end
        end
    end

    task automatic clear_logs;
        rd_log.delete();
        wr_log.delete();
        ld_op.delete();
        ld_val.delete();
        both_cnt   = 0;
        ill_cycles = 0;
        ill_pulses = 0;
        unstable   = 0;
    endtask

    task automatic fill_mem;
        for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
    endtask

    task automatic load_demo;
        fill_mem();
        mem[12'h000] = 16'h1010;
        mem[12'h001] = 16'h2011;
        mem[12'h002] = 16'h5012;
        mem[12'h003] = 16'hF000;
        mem[12'h010] = 16'h0005;
        mem[12'h011] = 16'h0003;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start, then count non-halted cycles from the first FETCH
    task automatic run_prog(input int limit, output int cyc,
                            output bit done);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (halted) begin
                done = 1'b1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_rd, mem_wr, load_acc, halted, illegal} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {mem_rd, mem_wr, load_acc, halted, illegal});
        end
        n_cmp++;
        if (pc !== 12'h000 || operand !== 16'h0 || alu_op !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_regs pc=%h op=%h alu=%0d want 000/0000/0",
                     pc, operand, alu_op);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_rd !== 1'b0 || pc !== 12'h000) begin
            n_bad++;
            $display("FAIL idle_no_start mem_rd=%b pc=%h want 0/000",
                     mem_rd, pc);
        end
    endtask

    task automatic test_program;
        int          cyc;
        bit          done;
        logic [11:0] exp_rd[$];
        exp_rd = '{12'h000, 12'h010, 12'h001, 12'h011, 12'h002, 12'h003};
        delay = 0;
        load_demo();
        do_reset();
        run_prog(100, cyc, done);
        n_cmp++;
        if (!done || cyc != 13) begin
            n_bad++;
            $display("FAIL prog_cycles done=%0b cyc=%0d want 1/13", done, cyc);
        end
        n_cmp++;
        if (ld_op.size() != 2) begin
            n_bad++;
            $display("FAIL prog_loads got=%0d want 2", ld_op.size());
        end else begin
            n_cmp++;
            if (ld_op[0] !== 3'd0 || ld_val[0] !== 16'h0005) begin
                n_bad++;
                $display("FAIL prog_lda alu=%0d opnd=%h want 0/0005",
                         ld_op[0], ld_val[0]);
            end
            n_cmp++;
            if (ld_op[1] !== 3'd1 || ld_val[1] !== 16'h0003) begin
                n_bad++;
                $display("FAIL prog_add alu=%0d opnd=%h want 1/0003",
                         ld_op[1], ld_val[1]);
            end
        end
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== 12'h012) begin
            n_bad++;
            $display("FAIL prog_store n=%0d want one write at 012",
                     wr_log.size());
        end
        n_cmp++;
        if (rd_log != exp_rd) begin
            n_bad++;
            $display("FAIL prog_reads got=%p want=%p", rd_log, exp_rd);
        end
        n_cmp++;
        if (pc !== 12'h004 || both_cnt != 0) begin
            n_bad++;
            $display("FAIL prog_pc pc=%h both=%0d want 004/0", pc, both_cnt);
        end
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (halted !== 1'b1 || pc !== 12'h004 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_sticky halted=%b pc=%h rd=%b want 1/004/0",
                     halted, pc, mem_rd);
        end
    endtask

    task automatic test_wait_states;
        int          cyc;
        bit          done;
        logic [11:0] exp_rd[$];
        exp_rd = '{12'h000, 12'h010, 12'h001, 12'h011, 12'h002, 12'h003};
        delay = 3;
        load_demo();
        do_reset();
        run_prog(200, cyc, done);
        n_cmp++;
        if (!done || cyc != 34) begin
            n_bad++;
            $display("FAIL wait_cycles done=%0b cyc=%0d want 1/34", done, cyc);
        end
        n_cmp++;
        if (ld_op.size() != 2 || ld_val[0] !== 16'h0005 ||
            ld_val[1] !== 16'h0003 || ld_op[1] !== 3'd1) begin
            n_bad++;
            $display("FAIL wait_loads n=%0d want 2 loads 5(PASS_B),3(ADD)",
                     ld_op.size());
        end
        n_cmp++;
        if (rd_log != exp_rd || wr_log.size() != 1) begin
            n_bad++;
            $display("FAIL wait_order reads=%p writes=%0d want=%p / 1",
                     rd_log, wr_log.size(), exp_rd);
        end
        n_cmp++;
        if (unstable != 0 || both_cnt != 0) begin
            n_bad++;
            $display("FAIL wait_stable unstable=%0d both=%0d want 0/0",
                     unstable, both_cnt);
        end
        delay = 0;
    endtask

    task automatic test_branch;
        int          cyc;
        bit          done;
        logic [11:0] exp_rd[$];
        delay = 0;
        fill_mem();
        mem[12'h000] = 16'h7100;
        acc_zero = 1'b1;
        do_reset();
        run_prog(50, cyc, done);
        exp_rd = '{12'h000, 12'h100};
        n_cmp++;
        if (!done || rd_log != exp_rd || pc !== 12'h101 || cyc != 4) begin
            n_bad++;
            $display("FAIL jz_taken reads=%p pc=%h cyc=%0d want=%p/101/4",
                     rd_log, pc, cyc, exp_rd);
        end
        acc_zero = 1'b0;
        do_reset();
        run_prog(50, cyc, done);
        exp_rd = '{12'h000, 12'h001};
        n_cmp++;
        if (!done || rd_log != exp_rd || pc !== 12'h002) begin
            n_bad++;
            $display("FAIL jz_not_taken reads=%p pc=%h want=%p/002",
                     rd_log, pc, exp_rd);
        end
        // NOP at 0xFFF: the fetch increment must wrap to 0x000
        mem[12'h000] = 16'h7FFF;
        mem[12'hFFF] = 16'h0000;
        acc_zero = 1'b1;
        do_reset();
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rd_log.size() >= 2) acc_zero = 1'b0;
            if (halted) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        exp_rd = '{12'h000, 12'hFFF, 12'h000, 12'h001};
        n_cmp++;
        if (!done || rd_log != exp_rd || pc !== 12'h002) begin
            n_bad++;
            $display("FAIL pc_wrap reads=%p pc=%h want=%p/002",
                     rd_log, pc, exp_rd);
        end
        mem[12'h000] = 16'h6FFF;
        mem[12'hFFF] = 16'h6020;
        do_reset();
        run_prog(50, cyc, done);
        exp_rd = '{12'h000, 12'hFFF, 12'h020};
        n_cmp++;
        if (!done || rd_log != exp_rd || pc !== 12'h021 || cyc != 6) begin
            n_bad++;
            $display("FAIL jmp_at_fff reads=%p pc=%h cyc=%0d want=%p/021/6",
                     rd_log, pc, cyc, exp_rd);
        end
    endtask

    task automatic test_illegal;
        int          cyc;
        bit          done;
        int          exp_ill;
        logic [11:0] exp_rd[$];
        delay    = 0;
        acc_zero = 1'b0;
        acc_neg  = 1'b0;
        fill_mem();
        mem[12'h000] = 16'hA000;
        mem[12'h001] = 16'h8000;
`ifdef ACC_CTRL_JN_EN
        exp_ill = 1;
`else
        exp_ill = 2;
`endif
        do_reset();
        run_prog(50, cyc, done);
        exp_rd = '{12'h000, 12'h001, 12'h002};
        n_cmp++;
        if (ill_pulses != exp_ill || ill_cycles != exp_ill) begin
            n_bad++;
            $display("FAIL illegal_pulse pulses=%0d cycles=%0d want %0d/%0d",
                     ill_pulses, ill_cycles, exp_ill, exp_ill);
        end
        n_cmp++;
        if (!done || rd_log != exp_rd || cyc != 6) begin
            n_bad++;
            $display("FAIL illegal_continue reads=%p cyc=%0d want=%p/6",
                     rd_log, cyc, exp_rd);
        end
        fill_mem();
        mem[12'h000] = 16'h8050;
        acc_neg = 1'b1;
`ifdef ACC_CTRL_JN_EN
        exp_rd  = '{12'h000, 12'h050};
        exp_ill = 0;
`else
        exp_rd  = '{12'h000, 12'h001};
        exp_ill = 1;
`endif
        do_reset();
        run_prog(50, cyc, done);
        n_cmp++;
        if (!done || rd_log != exp_rd || ill_pulses != exp_ill) begin
            n_bad++;
            $display("FAIL jn_neg reads=%p ill=%0d want=%p/%0d",
                     rd_log, ill_pulses, exp_rd, exp_ill);
        end
        acc_neg = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit done;
        bit found;
        delay = 3;
        load_demo();
        do_reset();
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (mem_rd && mem_addr == 12'h011) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_reach got=no ADD operand read want=reached");
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || pc !== 12'h000) begin
            n_bad++;
            $display("FAIL mid_reset rd=%b wr=%b pc=%h want 0/0/000",
                     mem_rd, mem_wr, pc);
        end
        n_cmp++;
        if (operand !== 16'h0 || alu_op !== 3'd0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_regs op=%h alu=%0d halted=%b want 0/0/0",
                     operand, alu_op, halted);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_rd !== 1'b0 || load_acc !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_idle rd=%b ld=%b want 0/0", mem_rd, load_acc);
        end
        delay = 0;
        run_prog(100, cyc, done);
        n_cmp++;
        if (!done || cyc != 13 || rd_log.size() == 0 ||
            rd_log[0] !== 12'h000) begin
            n_bad++;
            $display("FAIL mid_restart done=%0b cyc=%0d want 1/13 from 000",
                     done, cyc);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        acc_zero = 1'b0;
        acc_neg  = 1'b0;
        delay    = 0;
        fill_mem();
        test_reset();
        test_program();
        test_wait_states();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
